// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into the shared stall bus, sequences
// exception/ERET redirects into a one-cycle registered flush, and keeps watchdog/perf counters.
module pipe_ctrl #(
  parameter int unsigned StallBus = 6,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_from_id,
  input  logic                stallreq_from_ex,
  input  logic                stallreq_from_mem,
  input  logic                excp_valid,
  input  logic [31:0]         excp_target,
  input  logic                eret_valid,
  input  logic [31:0]         epc,
  output logic [StallBus-1:0] stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                stall_timeout,
  output logic [CNT_W-1:0]    stall_cycle_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

  localparam logic [StallBus-1:0] StallMem = StallBus'(6'b011111);
  localparam logic [StallBus-1:0] StallEx  = StallBus'(6'b001111);
  localparam logic [StallBus-1:0] StallId  = StallBus'(6'b000111);

  typedef enum logic [1:0] {StIdle, StFlush, StHold} state_e;

  state_e             state_q, state_d;
  logic [31:0]        new_pc_q, new_pc_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [WdW-1:0]     wd_cnt_q, wd_cnt_d;
  logic               timeout_q, timeout_d;
  logic [StallBus-1:0] stall_vec;
  logic               accept;

  // Stall bus: highest-priority requester wins; suppressed while flushing or in reset.
  always_comb begin
    stall_vec = '0;
    if (!rst && state_q != StFlush) begin
      if (stallreq_from_mem)     stall_vec = StallMem;
      else if (stallreq_from_ex) stall_vec = StallEx;
      else if (stallreq_from_id) stall_vec = StallId;
    end
  end

  always_comb begin
    state_d     = state_q;
    new_pc_d    = new_pc_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A pending data access blocks the redirect; the source keeps its request up.
        if ((excp_valid || eret_valid) && !stallreq_from_mem) begin
          accept   = 1'b1;
          state_d  = StFlush;
          new_pc_d = excp_valid ? excp_target : epc;
        end
      end
      StFlush: state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (stall_vec != '0 && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (state_q == StFlush || stall_vec == '0) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WdMax) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
    if (wd_cnt_d == WdMax) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      new_pc_q    <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      new_pc_q    <= new_pc_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall           = stall_vec;
  assign flush           = (state_q == StFlush);
  assign new_pc          = new_pc_q;
  assign stall_timeout   = timeout_q;
  assign stall_cycle_cnt = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It merges stall requests from ID, EX and MEM into the shared stall bus consumed by every pipeline register (PC, IF, ID, EX, MEM, WB). It sequences exception and ERET redirects into a registered flush plus new_pc. It also keeps a stall watchdog and performance counters.

Parameters:
StallBus, 6, width of the stall bus: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. Stop=1, NoStop=0.
TIMEOUT, 1024, consecutive stalled cycles that set the sticky watchdog flag.
CNT_W, 32, width of the performance counters.

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
stallreq_from_id  input  1  load-use hazard
stallreq_from_ex  input  1  multi-cycle mul/div busy
stallreq_from_mem  input  1  data SRAM access pending
excp_valid  input  1  exception detected in MEM
excp_target  input  32  handler address for excp_valid
eret_valid  input  1  ERET retiring in MEM
epc  input  32  return address for eret_valid
stall  output  StallBus  per-stage stop vector
flush  output  1  clear all pipeline registers
new_pc  output  32  redirect target, valid when flush=1
stall_timeout  output  1  sticky watchdog error
stall_cycle_cnt  output  CNT_W  cycles with stall!=0
flush_cnt  output  CNT_W  flushes issued

Behaviour:
- Reset values: stall=0 (forced 0 while rst=1), flush=0, new_pc=0, stall_timeout=0, both counters=0, state=IDLE, watchdog count=0.
- Stall encoding (combinational, same cycle as requests). Highest-priority requester wins:
  - MEM: 6'b011111
  - else EX: 6'b001111
  - else ID: 6'b000111
  - else 6'b000000
  - Bit 5 is never set. The downstream register injects a bubble where stall[i]=Stop and stall[i+1]=NoStop.
- FSM states IDLE, FLUSH, HOLD.
  - IDLE: a redirect is accepted when (excp_valid | eret_valid) & ~stallreq_from_mem.
    - excp_valid beats eret_valid when both are high.
    - The target is latched: excp_target or epc.
    - Next state is FLUSH.
    - If stallreq_from_mem=1, nothing is latched. The request must be held by the source and is re-evaluated every cycle.
  - FLUSH (exactly 1 cycle): flush=1 and new_pc=latched target, both registered (valid the cycle after acceptance). stall is forced to 0 regardless of requests. flush_cnt increments. Next state is HOLD.
  - HOLD (1 cycle): flush=0. excp_valid and eret_valid are ignored, covering residual signals from the flushed MEM contents. stall follows requests normally. Next state is IDLE.
- new_pc holds its last value outside FLUSH. Only flush qualifies it.
- Watchdog: counts consecutive cycles with stall!=0. It clears on any cycle with stall==0 and in FLUSH. When the count reaches TIMEOUT, stall_timeout=1 and stays set until rst. The count saturates at TIMEOUT.
- Counters:
  - stall_cycle_cnt increments on every cycle with stall!=0.
  - Both counters saturate at all-ones (no wrap).
- Reset mid-FLUSH or mid-HOLD returns to IDLE on the next edge: flush=0, the latched target is cleared, and counters are cleared.
- No combinational path from excp_valid/eret_valid to flush or new_pc.

Test Plan:
1. Request combinations: id=1 only -> stall=6'b000111; ex=1 & id=1 -> 6'b001111; mem=1 with all others -> 6'b011111; none -> 0. Each takes effect in the same cycle.
2. Exception: excp_valid=1, excp_target=32'hBFC00380 at cycle N -> cycle N+1 flush=1, new_pc=32'hBFC00380, stall=0 even with id=1, flush_cnt=1 -> cycle N+2 flush=0.
3. Exception blocked by MEM: excp_valid=1 with mem=1 for 3 cycles, then mem=0 -> flush asserted exactly 1 cycle after mem drops, once only.
4. Simultaneous excp_valid and eret_valid (epc=32'h80001000) -> new_pc=excp_target. Then excp_valid held high in HOLD -> no second flush; flush_cnt=1.
5. Watchdog with TIMEOUT=8: ex=1 for 8 cycles -> stall_timeout=1 after the 8th stalled cycle. Deassert ex -> flag stays 1. Pulse rst -> 0. Check stall_cycle_cnt=8 before the reset.
6. rst asserted the cycle flush=1 -> next cycle flush=0, state IDLE, stall=0, all counters 0.
